// File: rtl/exmem_stage_buf.sv
// ---------------------------------------------------------------------------
// exmem_stage_buf
//
// EX/MEM pipeline stage buffer for the MIPS core. It carries EX results and
// MEM/WB controls to the MEM stage. With SKID=1 it holds up to two entries:
// a head and a skid. Its in_ready is registered, so there is no combinational
// path from out_ready to in_ready. With SKID=0 it holds one entry, and
// in_ready passes out_ready through combinationally.
// All state changes on the falling edge of clock.
//
// Handshake: an input transfer happens on an edge where in_valid & in_ready.
// An output transfer happens on an edge where out_valid & out_ready. Once
// valid is raised, the producer keeps its payload stable until the transfer.
// flush overrides both transfers at its edge and empties the stage.
//
// Ports
//   clock, reset_n        falling-edge clock, async active-low reset
//   flush                 squash every entry at the next edge
//   in_valid / in_ready   EX side handshake
//   in_ctl                {mem_to_reg, reg_write, mem_read, mem_write}
//   in_jsel, in_addr, in_wdata, in_dst, in_instr   payload from EX
//   out_valid / out_ready MEM side handshake
//   out_ctl               head controls, zero whenever out_valid = 0
//   out_jsel, out_addr, out_wdata, out_dst, out_instr  head payload
//   load_busy, load_dst   a valid entry is a load / dst of youngest load
//   count                 number of valid entries
//   fsm_state             occupancy state (0 EMPTY, 1 ONE, 2 FULL)
// ---------------------------------------------------------------------------
module exmem_stage_buf #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int SKID   = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_ctl,
    input  logic [DATA_W-1:0] in_jsel,
    input  logic [DATA_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [REG_W-1:0]  in_dst,
    input  logic [DATA_W-1:0] in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_ctl,
    output logic [DATA_W-1:0] out_jsel,
    output logic [DATA_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_wdata,
    output logic [REG_W-1:0]  out_dst,
    output logic [DATA_W-1:0] out_instr,
    output logic              load_busy,
    output logic [REG_W-1:0]  load_dst,
    output logic [1:0]        count,
    output logic [1:0]        fsm_state
);

    localparam bit HAS_SKID = (SKID != 0);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]        ctl;
        logic [DATA_W-1:0] jsel;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [REG_W-1:0]  dst;
        logic [DATA_W-1:0] instr;
    } entry_t;

    state_t state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   in_ready_q;
    logic   push, pop;
    logic   head_load, skid_load;

    assign in_entry  = {in_ctl, in_jsel, in_addr, in_wdata, in_dst, in_instr};
    assign out_valid = (state_q != EMPTY);

    // SKID=1 uses the registered ready. SKID=0 may accept in the same edge the
    // head leaves, so its ready looks at out_ready directly.
    assign in_ready = HAS_SKID ? in_ready_q : (out_ready | ~out_valid);

    // flush wins over both transfers on its edge.
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_d  = in_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_d = in_entry;
                    end else if (push && HAS_SKID) begin
                        skid_d  = in_entry;
                        state_d = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        head_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    // Payload registers keep stale data after pop/flush. Only the strobes are
    // gated, so a bubble can never write memory or the register file.
    assign out_ctl   = out_valid ? head_q.ctl : 4'b0;
    assign out_jsel  = head_q.jsel;
    assign out_addr  = head_q.addr;
    assign out_wdata = head_q.wdata;
    assign out_dst   = head_q.dst;
    assign out_instr = head_q.instr;

    // mem_read is ctl[1]. The skid entry is younger, so it takes priority.
    assign head_load = out_valid & head_q.ctl[1];
    assign skid_load = (state_q == FULL) & skid_q.ctl[1];
    assign load_busy = head_load | skid_load;
    assign load_dst  = skid_load ? skid_q.dst :
                       head_load ? head_q.dst : '0;

    assign count     = state_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_exmem_stage_buf.sv
module tb_exmem_stage_buf;

  typedef struct packed {
    logic [3:0]  ctl;
    logic [31:0] jsel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  dst;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    bit          iv;
    bit          ordy;
    bit          fl;
    logic [3:0]  ctl;
    logic [31:0] addr;
    logic [4:0]  dst;
    logic [1:0]  e_cnt;
    bit          e_ov;
    logic [31:0] e_addr;
    logic [3:0]  e_ctl;
    bit          e_lb;
    logic [4:0]  e_ld;
    bit          e_ir;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT a: SKID=1 ----------------
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_load_busy;
  logic [3:0]  a_in_ctl, a_out_ctl;
  logic [31:0] a_in_jsel, a_in_addr, a_in_wdata, a_in_instr;
  logic [31:0] a_out_jsel, a_out_addr, a_out_wdata, a_out_instr;
  logic [4:0]  a_in_dst, a_out_dst, a_load_dst;
  logic [1:0]  a_count, a_state;

  exmem_stage_buf #(.DATA_W(32), .REG_W(5), .SKID(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctl(a_in_ctl),
    .in_jsel(a_in_jsel), .in_addr(a_in_addr), .in_wdata(a_in_wdata),
    .in_dst(a_in_dst), .in_instr(a_in_instr),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctl(a_out_ctl),
    .out_jsel(a_out_jsel), .out_addr(a_out_addr), .out_wdata(a_out_wdata),
    .out_dst(a_out_dst), .out_instr(a_out_instr),
    .load_busy(a_load_busy), .load_dst(a_load_dst), .count(a_count),
    .fsm_state(a_state)
  );

  // ---------------- DUT b: SKID=0 ----------------
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_load_busy;
  logic [3:0]  b_in_ctl, b_out_ctl;
  logic [31:0] b_in_jsel, b_in_addr, b_in_wdata, b_in_instr;
  logic [31:0] b_out_jsel, b_out_addr, b_out_wdata, b_out_instr;
  logic [4:0]  b_in_dst, b_out_dst, b_load_dst;
  logic [1:0]  b_count, b_state;

  exmem_stage_buf #(.DATA_W(32), .REG_W(5), .SKID(0)) dut_b (
    .clock(clock), .reset_n(reset_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctl(b_in_ctl),
    .in_jsel(b_in_jsel), .in_addr(b_in_addr), .in_wdata(b_in_wdata),
    .in_dst(b_in_dst), .in_instr(b_in_instr),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctl(b_out_ctl),
    .out_jsel(b_out_jsel), .out_addr(b_out_addr), .out_wdata(b_out_wdata),
    .out_dst(b_out_dst), .out_instr(b_out_instr),
    .load_busy(b_load_busy), .load_dst(b_load_dst), .count(b_count),
    .fsm_state(b_state)
  );

  // ---------------- scoreboard state ----------------
  int   n_cmp = 0;
  int   n_bad = 0;
  ent_t qa[$];
  ent_t qb[$];
  vec_t vt[14];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ent_t rand_ent();
    ent_t e;
    e.ctl   = 4'($urandom_range(0, 15));
    e.jsel  = $urandom;
    e.addr  = $urandom;
    e.wdata = $urandom;
    e.dst   = 5'($urandom_range(0, 31));
    e.instr = $urandom;
    return e;
  endfunction

  // Reference: the stage is a FIFO of capacity 2 (skid) or 1 (no skid).
  // Outputs follow from the queue contents alone.
  task automatic check_dut(input string tag, input bit skid, input ent_t q[$],
                           input logic ordy, input logic ir, input logic ov,
                           input ent_t head, input logic lb, input logic [4:0] ld,
                           input logic [1:0] cnt);
    bit         exp_lb = 1'b0;
    logic [4:0] exp_ld = 5'd0;
    foreach (q[i]) begin
      if (q[i].ctl[1]) begin
        exp_lb = 1'b1;
        exp_ld = q[i].dst;
      end
    end
    cmp({tag, ".in_ready"}, 64'(ir), skid ? 64'(q.size() < 2) : 64'(ordy || q.size() == 0));
    cmp({tag, ".count"}, 64'(cnt), 64'(q.size()));
    cmp({tag, ".out_valid"}, 64'(ov), 64'(q.size() > 0));
    cmp({tag, ".load_busy"}, 64'(lb), 64'(exp_lb));
    cmp({tag, ".load_dst"}, 64'(ld), 64'(exp_ld));
    if (q.size() > 0) begin
      cmp({tag, ".out_ctl"}, 64'(head.ctl), 64'(q[0].ctl));
      cmp({tag, ".out_addr"}, 64'(head.addr), 64'(q[0].addr));
      cmp({tag, ".out_jsel"}, 64'(head.jsel), 64'(q[0].jsel));
      cmp({tag, ".out_wdata"}, 64'(head.wdata), 64'(q[0].wdata));
      cmp({tag, ".out_dst"}, 64'(head.dst), 64'(q[0].dst));
      cmp({tag, ".out_instr"}, 64'(head.instr), 64'(q[0].instr));
    end else begin
      cmp({tag, ".bubble_ctl"}, 64'(head.ctl), 64'd0);
    end
  endtask

  // ---------------- driver ----------------
  // One clock: drive at posedge, check pre-edge outputs against the model,
  // then advance the model across the falling (active) edge.
  task automatic cycle_step(input bit a_iv, input bit a_or, input bit a_fl,
                            input bit b_iv, input bit b_or, input bit b_fl);
    ent_t ea, eb;
    bit   a_push, a_pop, b_push, b_pop;
    @(posedge clock);
    ea = rand_ent();
    eb = rand_ent();
    a_in_valid = a_iv; a_out_ready = a_or; a_flush = a_fl;
    {a_in_ctl, a_in_jsel, a_in_addr, a_in_wdata, a_in_dst, a_in_instr} = ea;
    b_in_valid = b_iv; b_out_ready = b_or; b_flush = b_fl;
    {b_in_ctl, b_in_jsel, b_in_addr, b_in_wdata, b_in_dst, b_in_instr} = eb;
    #1;
    check_dut("a", 1'b1, qa, a_or, a_in_ready, a_out_valid,
              {a_out_ctl, a_out_jsel, a_out_addr, a_out_wdata, a_out_dst, a_out_instr},
              a_load_busy, a_load_dst, a_count);
    check_dut("b", 1'b0, qb, b_or, b_in_ready, b_out_valid,
              {b_out_ctl, b_out_jsel, b_out_addr, b_out_wdata, b_out_dst, b_out_instr},
              b_load_busy, b_load_dst, b_count);
    a_push = a_iv && !a_fl && (qa.size() < 2);
    a_pop  = a_or && !a_fl && (qa.size() > 0);
    b_push = b_iv && !b_fl && (b_or || qb.size() == 0);
    b_pop  = b_or && !b_fl && (qb.size() > 0);
    @(negedge clock);
    if (a_fl) qa.delete();
    else begin
      if (a_pop) void'(qa.pop_front());
      if (a_push) qa.push_back(ea);
    end
    if (b_fl) qb.delete();
    else begin
      if (b_pop) void'(qb.pop_front());
      if (b_push) qb.push_back(eb);
    end
  endtask

  function automatic vec_t mk(input bit iv, input bit ordy, input bit fl,
                              input logic [3:0] ctl, input logic [31:0] addr,
                              input logic [4:0] dst, input logic [1:0] e_cnt,
                              input bit e_ov, input logic [31:0] e_addr,
                              input logic [3:0] e_ctl, input bit e_lb,
                              input logic [4:0] e_ld, input bit e_ir);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.ctl = ctl; v.addr = addr; v.dst = dst;
    v.e_cnt = e_cnt; v.e_ov = e_ov; v.e_addr = e_addr; v.e_ctl = e_ctl;
    v.e_lb = e_lb; v.e_ld = e_ld; v.e_ir = e_ir;
    return v;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    // Expected state after each falling edge, SKID=1, starting empty.
    vt[0]  = mk(1, 1, 0, 4'hE, 32'h10, 5'd8, 2'd1, 1, 32'h10, 4'hE, 1, 5'd8, 1);
    vt[1]  = mk(0, 1, 0, 4'h0, 32'h0,  5'd0, 2'd0, 0, 32'h0,  4'h0, 0, 5'd0, 1);
    vt[2]  = mk(1, 0, 0, 4'h4, 32'hA,  5'd3, 2'd1, 1, 32'hA,  4'h4, 0, 5'd0, 1);
    vt[3]  = mk(1, 0, 0, 4'hE, 32'hB,  5'd9, 2'd2, 1, 32'hA,  4'h4, 1, 5'd9, 0);
    vt[4]  = mk(1, 0, 0, 4'h1, 32'hC,  5'd1, 2'd2, 1, 32'hA,  4'h4, 1, 5'd9, 0);
    vt[5]  = mk(0, 1, 0, 4'h0, 32'h0,  5'd0, 2'd1, 1, 32'hB,  4'hE, 1, 5'd9, 1);
    vt[6]  = mk(0, 1, 0, 4'h0, 32'h0,  5'd0, 2'd0, 0, 32'h0,  4'h0, 0, 5'd0, 1);
    vt[7]  = mk(1, 0, 0, 4'hE, 32'h20, 5'd4, 2'd1, 1, 32'h20, 4'hE, 1, 5'd4, 1);
    vt[8]  = mk(1, 0, 0, 4'hE, 32'h21, 5'd5, 2'd2, 1, 32'h20, 4'hE, 1, 5'd5, 0);
    vt[9]  = mk(1, 1, 1, 4'h6, 32'h22, 5'd6, 2'd0, 0, 32'h0,  4'h0, 0, 5'd0, 1);
    vt[10] = mk(0, 1, 0, 4'h0, 32'h0,  5'd0, 2'd0, 0, 32'h0,  4'h0, 0, 5'd0, 1);
    vt[11] = mk(1, 1, 0, 4'h2, 32'h30, 5'd7, 2'd1, 1, 32'h30, 4'h2, 1, 5'd7, 1);
    vt[12] = mk(1, 0, 0, 4'h4, 32'h31, 5'd2, 2'd2, 1, 32'h30, 4'h2, 1, 5'd7, 0);
    vt[13] = mk(0, 1, 0, 4'h0, 32'h0,  5'd0, 2'd1, 1, 32'h31, 4'h4, 0, 5'd0, 1);

    a_flush = 0; a_in_valid = 0; a_out_ready = 0;
    {a_in_ctl, a_in_jsel, a_in_addr, a_in_wdata, a_in_dst, a_in_instr} = '0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 0;
    {b_in_ctl, b_in_jsel, b_in_addr, b_in_wdata, b_in_dst, b_in_instr} = '0;

    // Reset state
    #12;
    cmp("rst.a.in_ready", 64'(a_in_ready), 64'd1);
    cmp("rst.a.out_valid", 64'(a_out_valid), 64'd0);
    cmp("rst.a.out_ctl", 64'(a_out_ctl), 64'd0);
    cmp("rst.a.count", 64'(a_count), 64'd0);
    cmp("rst.a.load_busy", 64'(a_load_busy), 64'd0);
    cmp("rst.a.out_addr", 64'(a_out_addr), 64'd0);
    cmp("rst.a.state", 64'(a_state), 64'd0);
    cmp("rst.b.in_ready", 64'(b_in_ready), 64'd1);
    cmp("rst.b.count", 64'(b_count), 64'd0);
    cmp("rst.b.state", 64'(b_state), 64'd0);
    @(posedge clock);
    reset_n = 1'b1;

    // Table-driven directed vectors on the skid variant
    foreach (vt[i]) begin
      @(posedge clock);
      a_in_valid = vt[i].iv; a_out_ready = vt[i].ordy; a_flush = vt[i].fl;
      a_in_ctl = vt[i].ctl; a_in_addr = vt[i].addr; a_in_dst = vt[i].dst;
      a_in_jsel = 32'(i); a_in_wdata = ~32'(i); a_in_instr = 32'h1000 + 32'(i);
      @(negedge clock);
      #1;
      cmp($sformatf("vec%0d.count", i), 64'(a_count), 64'(vt[i].e_cnt));
      cmp($sformatf("vec%0d.out_valid", i), 64'(a_out_valid), 64'(vt[i].e_ov));
      cmp($sformatf("vec%0d.out_ctl", i), 64'(a_out_ctl), 64'(vt[i].e_ctl));
      cmp($sformatf("vec%0d.load_busy", i), 64'(a_load_busy), 64'(vt[i].e_lb));
      cmp($sformatf("vec%0d.load_dst", i), 64'(a_load_dst), 64'(vt[i].e_ld));
      cmp($sformatf("vec%0d.in_ready", i), 64'(a_in_ready), 64'(vt[i].e_ir));
      if (vt[i].e_ov)
        cmp($sformatf("vec%0d.out_addr", i), 64'(a_out_addr), 64'(vt[i].e_addr));
    end

    // Reset mid-stream with two entries held
    @(posedge clock);
    a_in_valid = 1; a_out_ready = 0; a_in_ctl = 4'h1; a_in_addr = 32'h40; a_in_dst = 5'd1;
    @(negedge clock);
    #1;
    cmp("midrst.pre_count", 64'(a_count), 64'd2);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    cmp("midrst.count", 64'(a_count), 64'd0);
    cmp("midrst.out_valid", 64'(a_out_valid), 64'd0);
    cmp("midrst.out_ctl", 64'(a_out_ctl), 64'd0);
    cmp("midrst.in_ready", 64'(a_in_ready), 64'd1);
    cmp("midrst.load_busy", 64'(a_load_busy), 64'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
    cmp("rst_release.no_accept", 64'(a_count), 64'd0);
    @(negedge clock);
    #1;
    cmp("rst_release.first_edge", 64'(a_count), 64'd1);
    cmp("rst_release.out_addr", 64'(a_out_addr), 64'h40);
    @(posedge clock);
    a_in_valid = 0; a_out_ready = 1;
    @(negedge clock);
    #1;
    cmp("drain.count", 64'(a_count), 64'd0);
    qa.delete();
    qb.delete();

    // Steady push+pop at count=1, output stream must equal input stream
    cycle_step(1, 0, 0, 1, 0, 0);
    for (int k = 0; k < 100; k++) begin
      cycle_step(1, 1, 0, 1, 1, 0);
      #1;
      cmp("steady.a.count", 64'(a_count), 64'd1);
    end

    // Randomized traffic, both variants, against the FIFO reference
    for (int k = 0; k < 10000; k++) begin
      cycle_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 31) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 31) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
